// File: rtl/instr_fetch_queue.sv
// Circular instruction buffer between imem and decode, head split into RV32 fields.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module instr_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_imem_valid,
  input  logic [XLEN-1:0]          i_imem_instr,
  input  logic [XLEN-1:0]          i_imem_pc,
  output logic                     o_imem_ready,
  output logic                     o_id_valid,
  input  logic                     i_id_ready,
  output logic [XLEN-1:0]          o_id_pc,
  output logic [XLEN-1:0]          o_id_instr,
  output logic [6:0]               o_opcode,
  output logic [4:0]               o_rd,
  output logic [2:0]               o_funct3,
  output logic [4:0]               o_rs1,
  output logic [4:0]               o_rs2,
  output logic [6:0]               o_funct7,
  output logic                     o_len_err,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            empty;
  logic            byp;
  logic            push;
  logic            pop;

  assign empty = (cnt_q == '0);

  assign o_imem_ready = !i_rst && !i_flush &&
                        (cnt_q < (AW+1)'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && i_imem_valid &&
               !i_flush && !i_rst;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    o_id_valid = !empty;
    o_id_pc    = '0;
    o_id_instr = NOP;
    if (!empty) begin
      o_id_pc    = pc_q[rd_q];
      o_id_instr = instr_q[rd_q];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (byp) begin
      o_id_valid = 1'b1;
      o_id_pc    = i_imem_pc;
      o_id_instr = i_imem_instr;
    end
`endif
  end

  // A bypassed entry taken by decode this cycle never lands in storage
  assign push = i_imem_valid && o_imem_ready &&
                !(byp && i_id_ready);
  assign pop  = !empty && i_id_ready && !i_flush;

  always_comb begin
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_q[wr_q]    <= i_imem_pc;
      instr_q[wr_q] <= i_imem_instr;
    end
  end

  assign o_opcode  = o_id_instr[6:0];
  assign o_rd      = o_id_instr[11:7];
  assign o_funct3  = o_id_instr[14:12];
  assign o_rs1     = o_id_instr[19:15];
  assign o_rs2     = o_id_instr[24:20];
  assign o_funct7  = o_id_instr[31:25];
  assign o_len_err = o_id_valid &&
                     (o_id_instr[1:0] != 2'b11);
  assign o_count   = cnt_q;

endmodule
